// File: rtl/lsu_align_if.sv
// Execute-stage request/response bundle for lsu_align.
interface lsu_align_if #(
  parameter int unsigned N = 32
);
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [2:0]   req_funct3;
  logic [N-1:0] req_addr;
  logic [N-1:0] req_wdata;
  logic         resp_valid;
  logic [N-1:0] resp_rdata;
  logic         resp_misalign;
  logic         resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_misalign, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_misalign, resp_err
  );
endinterface

// File: rtl/lsu_align.sv
// RV32I load/store aligner in front of a word-only dmem; sub-word stores become read-modify-write.
// Optional LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of truncating the address.
module lsu_align #(
  parameter int unsigned N          = 32,
  parameter int unsigned DMEM_BYTES = 1024
) (
  input  logic         clk,
  input  logic         rst_,
  lsu_align_if.slave   bus,
  output logic [N-1:0] dmem_addr,
  output logic [N-1:0] dmem_wdata,
  output logic         dmem_memrw,
  input  logic [N-1:0] dmem_rdata
);
  localparam int unsigned LAST_WORD = DMEM_BYTES - 4;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t       state;
  logic         ready_q, resp_valid_q, resp_misalign_q, resp_err_q;
  logic [N-1:0] resp_rdata_q;
  logic         we_q;
  logic [2:0]   funct3_q;
  logic [N-1:0] addr_q, wdata_q, word_q;

  logic         f3_ok_c, addr_err_c, mis_c, err_c;
  logic [N-1:0] addr_c;

  // Sub-word lane extraction with sign/zero extension.
  function automatic logic [N-1:0] load_ext(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [N-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {lo, 3'b000});
    h = 16'(w >> {lo[1], 4'b0000});
    case (f3)
      3'b000:  load_ext = {{(N-8){b[7]}}, b};
      3'b001:  load_ext = {{(N-16){h[15]}}, h};
      3'b100:  load_ext = N'(b);
      3'b101:  load_ext = N'(h);
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [N-1:0] store_merge(input logic [1:0] sz, input logic [1:0] lo,
                                               input logic [N-1:0] w, input logic [N-1:0] d);
    logic [N-1:0] m;
    m = w;
    case (sz)
      2'b00:   m[8*lo +: 8]     = d[7:0];
      2'b01:   m[16*lo[1] +: 16] = d[15:0];
      default: m = d;
    endcase
    return m;
  endfunction

  // Request decode: legality, range and natural alignment.
  always_comb begin
    f3_ok_c = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: f3_ok_c = 1'b1;
      3'b100, 3'b101:         f3_ok_c = !bus.req_we;
      default:                f3_ok_c = 1'b0;
    endcase
    addr_err_c = bus.req_addr > N'(LAST_WORD);
    err_c      = !f3_ok_c || addr_err_c;
    addr_c     = bus.req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
    mis_c = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
            ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    mis_c = 1'b0;
    if (bus.req_funct3[1:0] == 2'b01) addr_c[0]   = 1'b0;
    if (bus.req_funct3[1:0] == 2'b10) addr_c[1:0] = 2'b00;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state           <= IDLE;
      ready_q         <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      resp_misalign_q <= 1'b0;
      resp_err_q      <= 1'b0;
      we_q            <= 1'b0;
      funct3_q        <= 3'b000;
      addr_q          <= '0;
      wdata_q         <= '0;
      word_q          <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          we_q     <= bus.req_we;
          funct3_q <= bus.req_funct3;
          addr_q   <= addr_c;
          wdata_q  <= bus.req_wdata;
          ready_q  <= 1'b0;
          if (err_c || mis_c) begin
            state           <= RESP;
            resp_valid_q    <= 1'b1;
            resp_rdata_q    <= '0;
            resp_misalign_q <= mis_c;
            resp_err_q      <= err_c;
          end else if (bus.req_we && bus.req_funct3[1:0] == 2'b10) begin
            state <= WR;
          end else begin
            state <= RD;
          end
        end
        RD: begin
          word_q <= dmem_rdata;
          if (we_q) begin
            state <= WR;
          end else begin
            state           <= RESP;
            resp_valid_q    <= 1'b1;
            resp_rdata_q    <= load_ext(funct3_q, addr_q[1:0], dmem_rdata);
            resp_misalign_q <= 1'b0;
            resp_err_q      <= 1'b0;
          end
        end
        WR: begin
          state           <= RESP;
          resp_valid_q    <= 1'b1;
          resp_rdata_q    <= '0;
          resp_misalign_q <= 1'b0;
          resp_err_q      <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Write strobe is gated by reset so a reset landing in WR cannot corrupt dmem.
  assign dmem_memrw = (state == WR) && rst_;
  assign dmem_addr  = {addr_q[N-1:2], 2'b00};
  assign dmem_wdata = store_merge(funct3_q[1:0], addr_q[1:0], word_q, wdata_q);

  assign bus.req_ready     = ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.resp_misalign = resp_misalign_q;
  assign bus.resp_err      = resp_err_q;
endmodule

// File: tb/tb_lsu_align.sv
// Directed self-checking bench for lsu_align with a behavioural word-wide dmem.
module tb_lsu_align;
  logic clk = 1'b0;
  logic rst_ = 1'b0;
  logic init_mem = 1'b1;
  always #5 clk = ~clk;

  lsu_align_if #(.N(32)) bus ();
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_memrw;
  logic [31:0] mem [256];
  int n_cmp = 0;
  int n_bad = 0;

  lsu_align #(.N(32), .DMEM_BYTES(1024)) dut (
    .clk(clk), .rst_(rst_), .bus(bus),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_memrw(dmem_memrw), .dmem_rdata(dmem_rdata)
  );

  assign dmem_rdata = mem[dmem_addr[9:2]];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[0]   <= 32'h0000000A;
      mem[1]   <= 32'h11111111;
      mem[3]   <= 32'h33333333;
      mem[4]   <= 32'h0000000B;
      mem[255] <= 32'hCAFEF00D;
    end else if (dmem_memrw) begin
      mem[dmem_addr[9:2]] <= dmem_wdata;
    end
  end

  // Issue one request; lat is cycles from accept edge to resp_valid (0 on timeout).
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output logic [31:0] rd, output logic mis, output logic err,
                     output int wrs);
    lat = 0; wrs = 0; rd = 32'h0; mis = 1'b0; err = 1'b0;
    @(negedge clk);
    bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = d;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (dmem_memrw) wrs++;
      if (bus.resp_valid) begin
        lat = c; rd = bus.resp_rdata; mis = bus.resp_misalign; err = bus.resp_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", bus.resp_valid); end
    n_cmp++; if (bus.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got %h want 0", bus.resp_rdata); end
    n_cmp++; if ({bus.resp_misalign, bus.resp_err, dmem_memrw} !== 3'b000) begin n_bad++; $display("FAIL rst_flags got %b want 000", {bus.resp_misalign, bus.resp_err, dmem_memrw}); end
    rst_ = 1'b1; init_mem = 1'b0;
  endtask

  task automatic test_lw();
    int lat, wrs; logic [31:0] rd; logic mis, err;
    txn(1'b0, 3'b010, 32'h0, 32'h0, lat, rd, mis, err, wrs);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL lw_lat got %0d want 2", lat); end
    n_cmp++; if (rd !== 32'h0000000A) begin n_bad++; $display("FAIL lw_rdata got %h want 0000000a", rd); end
    n_cmp++; if ({err, wrs[0]} !== 2'b00 || wrs != 0) begin n_bad++; $display("FAIL lw_err_wr got err=%b wr=%0d want 0/0", err, wrs); end
  endtask

  task automatic test_store_load();
    int lat, wrs; logic [31:0] rd; logic mis, err;
    txn(1'b1, 3'b010, 32'h8, 32'h80FF1234, lat, rd, mis, err, wrs);
    n_cmp++; if (lat !== 2 || wrs != 1) begin n_bad++; $display("FAIL sw_lat_wr got %0d/%0d want 2/1", lat, wrs); end
    n_cmp++; if (mem[2] !== 32'h80FF1234) begin n_bad++; $display("FAIL sw_mem got %h want 80ff1234", mem[2]); end
    txn(1'b0, 3'b000, 32'h9, 32'h0, lat, rd, mis, err, wrs);
    n_cmp++; if (rd !== 32'h00000012) begin n_bad++; $display("FAIL lb9 got %h want 00000012", rd); end
    txn(1'b0, 3'b000, 32'hB, 32'h0, lat, rd, mis, err, wrs);
    n_cmp++; if (rd !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lbB got %h want ffffff80", rd); end
    txn(1'b0, 3'b100, 32'hB, 32'h0, lat, rd, mis, err, wrs);
    n_cmp++; if (rd !== 32'h00000080) begin n_bad++; $display("FAIL lbuB got %h want 00000080", rd); end
    txn(1'b0, 3'b101, 32'h8, 32'h0, lat, rd, mis, err, wrs);
    n_cmp++; if (rd !== 32'h00001234) begin n_bad++; $display("FAIL lhu8 got %h want 00001234", rd); end
  endtask

  task automatic test_rmw();
    int lat, wrs; logic [31:0] rd; logic mis, err;
    txn(1'b1, 3'b001, 32'hA, 32'h0000BEEF, lat, rd, mis, err, wrs);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL sh_lat got %0d want 3", lat); end
    n_cmp++; if (wrs != 1) begin n_bad++; $display("FAIL sh_wr got %0d want 1", wrs); end
    n_cmp++; if (mem[2] !== 32'hBEEF1234) begin n_bad++; $display("FAIL sh_mem got %h want beef1234", mem[2]); end
    txn(1'b0, 3'b001, 32'hA, 32'h0, lat, rd, mis, err, wrs);
    n_cmp++; if (rd !== 32'hFFFFBEEF) begin n_bad++; $display("FAIL lhA got %h want ffffbeef", rd); end
    txn(1'b1, 3'b000, 32'h8, 32'hAAAAAA55, lat, rd, mis, err, wrs);
    n_cmp++; if (mem[2] !== 32'hBEEF1255 || lat != 3) begin n_bad++; $display("FAIL sb_mem got %h lat %0d want beef1255 lat 3", mem[2], lat); end
  endtask

  task automatic test_misalign();
    int lat, wrs; logic [31:0] rd; logic mis, err;
    txn(1'b0, 3'b010, 32'h2, 32'h0, lat, rd, mis, err, wrs);
`ifdef LSU_MISALIGN_TRAP_EN
    n_cmp++; if (lat !== 1 || mis !== 1'b1 || rd !== 32'h0 || wrs != 0) begin n_bad++; $display("FAIL lw2_trap got lat%0d mis%b rd%h wr%0d want 1/1/0/0", lat, mis, rd, wrs); end
    txn(1'b0, 3'b001, 32'h9, 32'h0, lat, rd, mis, err, wrs);
    n_cmp++; if (lat !== 1 || mis !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL lh9_trap got lat%0d mis%b rd%h want 1/1/0", lat, mis, rd); end
`else
    n_cmp++; if (lat !== 2 || mis !== 1'b0 || rd !== 32'h0000000A) begin n_bad++; $display("FAIL lw2_trunc got lat%0d mis%b rd%h want 2/0/0000000a", lat, mis, rd); end
    txn(1'b0, 3'b001, 32'h9, 32'h0, lat, rd, mis, err, wrs);
    n_cmp++; if (mis !== 1'b0 || rd !== 32'h00001255) begin n_bad++; $display("FAIL lh9_trunc got mis%b rd%h want 0/00001255", mis, rd); end
`endif
  endtask

  task automatic test_reset_in_wr();
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_funct3 = 3'b000; bus.req_addr = 32'h10; bus.req_wdata = 32'h77;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (dmem_memrw !== 1'b1) begin n_bad++; $display("FAIL wr_reached got memrw %b want 1", dmem_memrw); end
    rst_ = 1'b0;
    #1;
    n_cmp++; if (dmem_memrw !== 1'b0) begin n_bad++; $display("FAIL wr_rst_memrw got %b want 0", dmem_memrw); end
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL wr_rst_idle got ready%b valid%b want 1/0", bus.req_ready, bus.resp_valid); end
    n_cmp++; if (mem[4] !== 32'h0000000B) begin n_bad++; $display("FAIL wr_rst_mem got %h want 0000000b", mem[4]); end
    rst_ = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] exp [3];
    int lat, wrs, got, extra; logic [31:0] rd; logic mis, err;
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'hC;
    exp[0] = 32'h0000000A; exp[1] = 32'h11111111; exp[2] = 32'h33333333;
    got = 0;
    @(negedge clk);
    bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.req_addr = addrs[k];
      n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_idle k%0d got %b want 1", k, bus.req_ready); end
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_busy k%0d got %b want 0", k, bus.req_ready); end
      for (int c = 0; c < 10 && !bus.resp_valid; c++) @(negedge clk);
      if (bus.resp_valid) got++;
      n_cmp++; if (bus.resp_rdata !== exp[k] || bus.resp_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_rdata k%0d got %h want %h", k, bus.resp_rdata, exp[k]); end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    extra = 0;
    repeat (4) begin @(negedge clk); if (bus.resp_valid) extra++; end
    n_cmp++; if (got != 3 || extra != 0) begin n_bad++; $display("FAIL b2b_count got %0d+%0d want 3+0", got, extra); end

    txn(1'b0, 3'b011, 32'h0, 32'h0, lat, rd, mis, err, wrs);
    n_cmp++; if (err !== 1'b1 || lat !== 1 || rd !== 32'h0) begin n_bad++; $display("FAIL f3_011 got err%b lat%0d rd%h want 1/1/0", err, lat, rd); end
    txn(1'b1, 3'b010, 32'h400, 32'hDEADBEEF, lat, rd, mis, err, wrs);
    n_cmp++; if (err !== 1'b1 || wrs != 0 || mem[0] !== 32'h0000000A) begin n_bad++; $display("FAIL sw_oor got err%b wr%0d mem0 %h want 1/0/0000000a", err, wrs, mem[0]); end
    txn(1'b0, 3'b010, 32'h3FC, 32'h0, lat, rd, mis, err, wrs);
    n_cmp++; if (err !== 1'b0 || rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL lw_last got err%b rd%h want 0/cafef00d", err, rd); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    test_reset();
    test_lw();
    test_store_load();
    test_rmw();
    test_misalign();
    test_reset_in_wr();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
